// File: rtl/ifu_pkg.sv
// Shared defines for the instruction fetch unit: reset vector, NOP encoding,
// bus response codes and the fetch FSM state encoding.
package ifu_pkg;

  localparam logic [31:0] CPU_RESET_ADDR = 32'h8000_0000;
  localparam logic [31:0] INST_NOP       = 32'h0000_0013;
  localparam logic [1:0]  RRESP_OKAY     = 2'b00;

  typedef enum logic [1:0] {
    ST_AR   = 2'd0,
    ST_R    = 2'd1,
    ST_OUT  = 2'd2,
    ST_KILL = 2'd3
  } ifu_state_e;

endpackage

// File: rtl/ifu.sv
// Instruction fetch unit: one outstanding instruction-bus read at a time,
// presents each fetched word to IF/ID and honours redirects from execute.
module ifu
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = CPU_RESET_ADDR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        arvalid,
  output logic [31:0] araddr,
  input  logic        arready,
  input  logic        rvalid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  output logic        rready,
  output logic        o_valid,
  input  logic        o_ready,
  output logic [31:0] o_pc,
  output logic [31:0] o_inst,
  output logic        o_err
);

  ifu_state_e  state;
  logic [31:0] pc;
  logic [31:0] pc_target;
  logic        kill_pending;

  // Handshake outputs depend on the state register alone.
  assign arvalid = (state == ST_AR);
  assign rready  = (state == ST_R) || (state == ST_KILL);
  assign o_valid = (state == ST_OUT);
  assign araddr  = pc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ST_AR;
      pc           <= RESET_PC;
      pc_target    <= RESET_PC;
      kill_pending <= 1'b0;
      o_pc         <= RESET_PC;
      o_inst       <= INST_NOP;
      o_err        <= 1'b0;
    end else begin
      unique case (state)
        ST_AR: begin
          // pc drives araddr, so a redirect while the address is still being
          // offered is parked in pc_target until the request is accepted.
          if (arready) begin
            state <= (redirect_valid || kill_pending) ? ST_KILL : ST_R;
            if (redirect_valid) begin
              pc <= redirect_pc;
            end else if (kill_pending) begin
              pc <= pc_target;
            end
            kill_pending <= 1'b0;
          end else if (redirect_valid) begin
            pc_target    <= redirect_pc;
            kill_pending <= 1'b1;
          end
        end

        ST_R: begin
          if (redirect_valid) begin
            pc    <= redirect_pc;
            state <= rvalid ? ST_AR : ST_KILL;
          end else if (rvalid) begin
            o_inst <= rdata;
            o_pc   <= pc;
            o_err  <= (rresp != RRESP_OKAY);
            state  <= ST_OUT;
          end
        end

        ST_OUT: begin
          if (redirect_valid) begin
            pc    <= redirect_pc;
            state <= ST_AR;
          end else if (o_ready) begin
            pc    <= pc + 32'd4;
            state <= ST_AR;
          end
        end

        ST_KILL: begin
          if (redirect_valid) begin
            pc <= redirect_pc;
          end
          if (rvalid) begin
            kill_pending <= 1'b0;
            state        <= ST_AR;
          end
        end

        default: state <= ST_AR;
      endcase
    end
  end

endmodule
